// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master drives requests and operands; the slave returns status and the HI/LO registers.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: WIDTH-cycle shift-add multiply or
// restoring divide on operand magnitudes, then a single sign-fix/accumulate cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         Clock,
  input  logic         nReset,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;

  // Operand magnitudes at issue; Op[0]=0 marks the signed variants.
  logic             in_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    in_signed = ~bus.Op[0];
    mag_a     = (in_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    mag_b     = (in_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  end

  // prod holds {upper, lower}: product accumulator with multiplier in the low half,
  // or {remainder, quotient-with-remaining-dividend-bits} for division.
  logic               is_div_q;
  logic               signed_q;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_nxt;

  always_comb begin
    is_div_q = (op_q[2:1] == 2'b01);
    signed_q = ~op_q[0];
    add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    prod_nxt = {add_sum, prod[WIDTH-1:1]};
    if (is_div_q) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      if (!diff[WIDTH]) prod_nxt = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      else              prod_nxt = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] acc_res;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;

  always_comb begin
    prod_s  = (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod : prod;
    q_s     = (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    r_s     = (signed_q && a_q[WIDTH-1]) ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    acc_res = op_q[1] ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    if (is_div_q) begin
      if (b_q == '0) begin
        hi_nxt = a_q;
        lo_nxt = '1;
      end else begin
        hi_nxt = r_s;
        lo_nxt = q_s;
      end
    end else if (op_q[2]) begin
      {hi_nxt, lo_nxt} = acc_res;
    end else begin
      {hi_nxt, lo_nxt} = prod_s;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opnd   <= '0;
      prod   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (bus.Flush) begin
        state  <= IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (bus.Start) begin
              if (!bus.Op[3]) begin
                op_q   <= bus.Op[2:0];
                a_q    <= bus.A;
                b_q    <= bus.B;
                opnd   <= mag_b;
                prod   <= {{WIDTH{1'b0}}, mag_a};
                cnt    <= '0;
                state  <= RUN;
                busy_q <= 1'b1;
              end else if (bus.Op[3:1] == 3'b100) begin
                if (bus.Op[0]) lo_q <= bus.A;
                else           hi_q <= bus.A;
                done_q <= 1'b1;
              end
            end
          end
          RUN: begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= is_div_q && (b_q == '0);
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases plus random ops
// compared against a 64-bit arithmetic reference of HI/LO.
module tb_muldiv_unit;

  localparam int W = 32;

  logic        Clock = 1'b0;
  logic        nReset;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] macc;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [63:0] acc, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    case (op)
      4'd0: acc = sa * sb;
      4'd1: acc = ua * ub;
      4'd2, 4'd3: begin
        if (b == 32'd0) begin
          acc = {a, 32'hFFFF_FFFF};
          dz  = 1'b1;
        end else if (op == 4'd2) begin
          q   = sa / sb;
          r   = sa % sb;
          acc = {r[31:0], q[31:0]};
        end else begin
          acc = {a % b, a / b};
        end
      end
      4'd4: acc = acc + sa * sb;
      4'd5: acc = acc + ua * ub;
      4'd6: acc = acc - sa * sb;
      4'd7: acc = acc - ua * ub;
      4'd8: acc[63:32] = a;
      4'd9: acc[31:0]  = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, input string tag);
    logic dz;
    int   lat, busy_n, dz_bad;
    model(op, a, b, macc, dz);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge Clock); #1;
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    lat = 0; busy_n = 0; dz_bad = 0;
    do begin
      @(negedge Clock);
      lat++;
      if (bus.Busy) busy_n++;
      if (bus.DivByZero && !bus.Done) dz_bad++;
      if (intrude && lat == 5) begin
        bus.Start = 1'b1;
        bus.Op    = 4'($urandom_range(0, 7));
      end
      if (intrude && lat == 6) bus.Start = 1'b0;
    end while (!bus.Done && lat < 100);
    chk({tag, "_latency"}, 64'(lat), 64'(W + 2));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W + 1));
    chk({tag, "_hilo"}, {bus.Hi, bus.Lo}, macc);
    chk({tag, "_dbz"}, {63'b0, bus.DivByZero}, {63'b0, dz});
    chk({tag, "_dbz_qualified"}, 64'(dz_bad), 64'd0);
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] a, input string tag);
    logic dz;
    model(op, a, 32'd0, macc, dz);
    bus.Start = 1'b1; bus.Op = op; bus.A = a;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    @(negedge Clock);
    chk({tag, "_done_busy"}, {62'b0, bus.Done, bus.Busy}, 64'b10);
    chk({tag, "_hilo"}, {bus.Hi, bus.Lo}, macc);
  endtask

  // Issues an operation without modelling it; returns in cycle T+10 (at its negedge).
  task automatic start_and_wait10(input logic [3:0] op);
    bus.Start = 1'b1; bus.Op = op; bus.A = $urandom; bus.B = $urandom;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge Clock);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge Clock);
      if (bus.Done) cnt++;
    end
  endtask

  initial begin
    int          nd;
    logic [3:0]  op;
    logic [31:0] ra, rb;

    nReset = 1'b0;
    bus.Start = 1'b0; bus.Op = 4'd0; bus.A = '0; bus.B = '0; bus.Flush = 1'b0;
    macc = '0;
    #12;
    chk("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    chk("reset_status", {61'b0, bus.Busy, bus.Done, bus.DivByZero}, 64'd0);
    @(negedge Clock);
    nReset = 1'b1;

    run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mult_neg");
    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu");
    run_op(4'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "div_neg7");
    run_op(4'd3, 32'h1234_5678, 32'h0000_0000, 1'b0, "divu_by0");
    mt_op(4'd8, 32'h0000_0000, "mthi");
    mt_op(4'd9, 32'hFFFF_FFFF, "mtlo");
    run_op(4'd5, 32'h0000_0001, 32'h0000_0001, 1'b0, "maddu_carry");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(4'd2, 32'h8765_4321, 32'h0000_0000, 1'b0, "div_by0");
    run_op(4'd6, 32'h0000_1234, 32'hFFFF_FF00, 1'b0, "msub");
    run_op(4'd4, 32'h8000_0000, 32'h8000_0000, 1'b0, "madd_min");
    run_op(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "msubu_max");
    run_op(4'd3, $urandom, $urandom_range(1, 255), 1'b1, "divu_intrude");

    // Reserved opcodes must be ignored.
    bus.Start = 1'b1; bus.Op = 4'($urandom_range(10, 15)); bus.A = $urandom;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    count_done(3, nd);
    chk("reserved_done", 64'(nd), 64'd0);
    chk("reserved_busy_hilo", {bus.Busy, bus.Hi[30:0], bus.Lo}, {1'b0, macc[62:0]});

    // Flush mid-operation.
    start_and_wait10(4'd0);
    bus.Flush = 1'b1;
    @(posedge Clock); #1;
    bus.Flush = 1'b0;
    @(negedge Clock);
    chk("flush_busy", {63'b0, bus.Busy}, 64'd0);
    count_done(40, nd);
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_hilo", {bus.Hi, bus.Lo}, macc);

    // Flush together with an MTHI request: the request is dropped.
    bus.Start = 1'b1; bus.Op = 4'd8; bus.A = ~macc[63:32]; bus.Flush = 1'b1;
    @(posedge Clock); #1;
    bus.Start = 1'b0; bus.Flush = 1'b0;
    count_done(2, nd);
    chk("flush_start_done", 64'(nd), 64'd0);
    chk("flush_start_hilo", {bus.Hi, bus.Lo}, macc);

    // Asynchronous reset mid-operation.
    start_and_wait10(4'd0);
    nReset = 1'b0;
    #1;
    chk("midreset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    chk("midreset_status", {61'b0, bus.Busy, bus.Done, bus.DivByZero}, 64'd0);
    macc = '0;
    @(negedge Clock);
    nReset = 1'b1;
    count_done(40, nd);
    chk("midreset_no_done", 64'(nd), 64'd0);

    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 9));
      ra = $urandom;
      rb = ($urandom_range(0, 6) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if (op >= 4'd8) mt_op(op, ra, "rand_mt");
      else            run_op(op, ra, rb, 1'b0, "rand_op");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
